// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with a registered one-hot grant held under valid/ready.
// Optional GNT_IDX_EN adds a registered binary index output gnt_idx.
module rr_arbiter8 #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             gnt_ready,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid
`ifdef GNT_IDX_EN
  ,
  output logic [IDX_W-1:0] gnt_idx
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] k;
  logic [N-1:0]     win_oh;
  logic             found;
  logic             accept;
  logic             any_req;

  assign accept  = (state == GRANT) && gnt_valid && gnt_ready;
  assign any_req = |req;

  // Index of the live grant, decoded from the one-hot register.
  always_comb begin
    cur_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) cur_idx = IDX_W'(i);
    end
  end

  // On accept the search starts just past the grant being retired.
  always_comb begin
    base    = accept ? (cur_idx + IDX_W'(1)) : ptr;
    win_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = base + IDX_W'(i);
      if (!found && req[k]) begin
        found   = 1'b1;
        win_idx = k;
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
`ifdef GNT_IDX_EN
      gnt_idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= win_oh;
            gnt_valid <= 1'b1;
            state     <= GRANT;
`ifdef GNT_IDX_EN
            gnt_idx   <= win_idx;
`endif
          end
        end
        GRANT: begin
          if (accept) begin
            ptr <= cur_idx + IDX_W'(1);
            if (any_req) begin
              gnt       <= win_oh;
              gnt_valid <= 1'b1;
`ifdef GNT_IDX_EN
              gnt_idx   <= win_idx;
`endif
            end else begin
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
`ifdef GNT_IDX_EN
              gnt_idx   <= '0;
`endif
            end
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic
// against a queue-free reference model of the round-robin rules.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       gnt_ready;
  logic [7:0] gnt;
  logic       gnt_valid;
`ifdef GNT_IDX_EN
  logic [2:0] gnt_idx;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: grant owner as an integer, pointer as an integer.
  int m_ptr   = 0;
  bit m_valid = 1'b0;
  int m_idx   = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.N(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
`ifdef GNT_IDX_EN
    ,
    .gnt_idx   (gnt_idx)
`endif
  );

  function automatic int search(input int start, input logic [7:0] r);
    for (int i = 0; i < 8; i++) begin
      if (r[(start + i) % 8]) return (start + i) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_gnt();
    logic [7:0] v;
    v = 8'h00;
    if (m_valid) v[m_idx] = 1'b1;
    return v;
  endfunction

  // Advance model and DUT by one clock; leaves time at posedge + 1.
  task automatic tick();
    int  np, ni;
    bit  nv;
    np = m_ptr; ni = m_idx; nv = m_valid;
    if (!m_valid) begin
      if (req != 8'h00) begin ni = search(m_ptr, req); nv = 1'b1; end
    end else if (gnt_ready) begin
      np = (m_idx + 1) % 8;
      if (req != 8'h00) ni = search(np, req);
      else begin nv = 1'b0; ni = 0; end
    end
    @(posedge clk);
    #1;
    m_ptr = np; m_idx = ni; m_valid = nv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    m_ptr = 0; m_idx = 0; m_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; gnt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      bad++; $display("FAIL reset_init gnt=%b valid=%b expected 00000000/0", gnt, gnt_valid);
    end
    rst = 1'b0;
    req = 8'b0000_0100;
    tick();
    total++;
    if (gnt !== 8'b0000_0100 || gnt_valid !== 1'b1) begin
      bad++; $display("FAIL reset_pre gnt=%b valid=%b expected 00000100/1", gnt, gnt_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      bad++; $display("FAIL reset_async gnt=%b valid=%b expected 00000000/0", gnt, gnt_valid);
    end
    m_ptr = 0; m_idx = 0; m_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req = 8'hFF;
    tick();
    total++;
    if (gnt !== 8'b0000_0001 || gnt_valid !== 1'b1) begin
      bad++; $display("FAIL reset_release gnt=%b valid=%b expected 00000001/1", gnt, gnt_valid);
    end
  endtask

  task automatic test_single();
    req = 8'h00; gnt_ready = 1'b1;
    tick();
    total++;
    if (gnt_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle valid=%b expected 0", gnt_valid);
    end
    req = 8'b0010_0000; gnt_ready = 1'b0;
    tick();
    total++;
    if (gnt !== 8'b0010_0000 || gnt_valid !== 1'b1) begin
      bad++; $display("FAIL single_gnt gnt=%b valid=%b expected 00100000/1", gnt, gnt_valid);
    end
`ifdef GNT_IDX_EN
    total++;
    if (gnt_idx !== 3'b101) begin
      bad++; $display("FAIL single_idx idx=%0d expected 5", gnt_idx);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'b1000_0001; gnt_ready = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      total++;
      if (gnt !== 8'b0000_0001 || gnt_valid !== 1'b1) begin
        bad++; $display("FAIL hold cycle=%0d gnt=%b expected 00000001", c, gnt);
      end
      tick();
    end
    gnt_ready = 1'b1;
    tick();
    total++;
    if (gnt !== 8'b1000_0000 || gnt_valid !== 1'b1) begin
      bad++; $display("FAIL hold_next gnt=%b expected 10000000", gnt);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] e;
    do_reset();
    req = 8'hFF; gnt_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      e = 8'h00;
      e[c % 8] = 1'b1;
      total++;
      if (gnt !== e || gnt_valid !== 1'b1) begin
        bad++; $display("FAIL rotate step=%0d gnt=%b valid=%b expected %b/1", c, gnt, gnt_valid, e);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 8'b0000_1000; gnt_ready = 1'b0;
    tick();
    req = 8'h00;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (gnt !== 8'b0000_1000 || gnt_valid !== 1'b1) begin
        bad++; $display("FAIL drop_hold cycle=%0d gnt=%b expected 00001000", c, gnt);
      end
    end
    gnt_ready = 1'b1;
    tick();
    total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      bad++; $display("FAIL drop_idle gnt=%b valid=%b expected 00000000/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req = 8'b0000_0011; gnt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (gnt !== ((c % 2 == 0) ? 8'b01 : 8'b10) || !$onehot(gnt)) begin
        bad++; $display("FAIL fair step=%0d gnt=%b expected %b", c, gnt, (c % 2 == 0) ? 8'b01 : 8'b10);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r, m;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = 8'($urandom_range(0, 255));
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      req = (c % 37 < 4) ? 8'h00 : (r & m);
      gnt_ready = ($urandom_range(0, 2) != 0);
      tick();
      total++;
      if (gnt !== exp_gnt() || gnt_valid !== m_valid) begin
        bad++; $display("FAIL rand c=%0d gnt=%b valid=%b expected %b/%b", c, gnt, gnt_valid, exp_gnt(), m_valid);
      end
      total++;
      if (gnt_valid ? !$onehot(gnt) : (gnt !== 8'h00)) begin
        bad++; $display("FAIL rand_onehot c=%0d gnt=%b valid=%b expected one-hot/zero", c, gnt, gnt_valid);
      end
`ifdef GNT_IDX_EN
      total++;
      if (gnt_idx !== 3'(m_valid ? m_idx : 0)) begin
        bad++; $display("FAIL rand_idx c=%0d idx=%0d expected %0d", c, gnt_idx, m_valid ? m_idx : 0);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_rotation();
    test_drop();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
